// File: rtl/cpu_pkg.sv
// Shared encodings and helpers for the datapath and its controller.
package cpu_pkg;

  localparam int DATA_W   = 16;
  localparam int NUM_REGS = 8;
  localparam int IDX_W    = $clog2(NUM_REGS);

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_NOT = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    SH_NONE = 2'b00,
    SH_LSL  = 2'b01,
    SH_LSR  = 2'b10,
    SH_ASR  = 2'b11
  } shift_op_e;

  typedef enum logic [1:0] {
    WB_C     = 2'b00,
    WB_PC    = 2'b01,
    WB_IMM8  = 2'b10,
    WB_MDATA = 2'b11
  } wb_sel_e;

  typedef enum logic [1:0] {
    SEL_RM  = 2'b00,
    SEL_RD  = 2'b01,
    SEL_RN  = 2'b10,
    SEL_RN2 = 2'b11
  } reg_sel_e;

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic              v;
  } alu_out_t;

  function automatic logic [DATA_W-1:0] shift16(shift_op_e op, logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] r;
    case (op)
      SH_LSL:  r = {b[DATA_W-2:0], 1'b0};
      SH_LSR:  r = {1'b0, b[DATA_W-1:1]};
      SH_ASR:  r = {b[DATA_W-1], b[DATA_W-1:1]};
      default: r = b;
    endcase
    return r;
  endfunction

  // Overflow uses the operand sign bits exactly as they enter the ALU.
  function automatic alu_out_t alu16(alu_op_e op, logic [DATA_W-1:0] a, logic [DATA_W-1:0] b);
    alu_out_t o;
    o.result = '0;
    o.v      = 1'b0;
    case (op)
      ALU_ADD: begin
        o.result = a + b;
        o.v      = (a[DATA_W-1] == b[DATA_W-1]) && (o.result[DATA_W-1] != a[DATA_W-1]);
      end
      ALU_SUB: begin
        o.result = a - b;
        o.v      = (a[DATA_W-1] != b[DATA_W-1]) && (o.result[DATA_W-1] != a[DATA_W-1]);
      end
      ALU_AND: o.result = a & b;
      default: o.result = ~b;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/datapath_if.sv
// Control/data bundle between the controller (master) and the datapath (slave).
interface datapath_if;
  import cpu_pkg::*;

  logic [IDX_W-1:0]  rn;
  logic [IDX_W-1:0]  rd;
  logic [IDX_W-1:0]  rm;
  reg_sel_e          reg_sel;
  wb_sel_e           wb_sel;
  logic              w_en;
  logic [DATA_W-1:0] mdata;
  logic [DATA_W-1:0] sximm8;
  logic [DATA_W-1:0] sximm5;
  logic [7:0]        pc;
  logic              en_A;
  logic              en_B;
  logic              en_C;
  logic              en_status;
  logic              sel_A;
  logic              sel_B;
  alu_op_e           ALU_op;
  shift_op_e         shift_op;
  logic [DATA_W-1:0] datapath_out;
  logic              Z;
  logic              N;
  logic              V;

  modport master (
    output rn, rd, rm, reg_sel, wb_sel, w_en, mdata, sximm8, sximm5, pc,
           en_A, en_B, en_C, en_status, sel_A, sel_B, ALU_op, shift_op,
    input  datapath_out, Z, N, V
  );

  modport slave (
    input  rn, rd, rm, reg_sel, wb_sel, w_en, mdata, sximm8, sximm5, pc,
           en_A, en_B, en_C, en_status, sel_A, sel_B, ALU_op, shift_op,
    output datapath_out, Z, N, V
  );

endinterface

// File: rtl/regfile.sv
// 8x16 register file: one combinational read port, one synchronous write port, async clear.
module regfile
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IDX_W-1:0]  idx,
  input  logic              w_en,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (w_en) begin
      regs[idx] <= wdata;
    end
  end

  assign rdata = regs[idx];

endmodule

// File: rtl/datapath.sv
// Register file, A/B operand latches, B shifter, ALU and C/status result registers.
module datapath
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  datapath_if.slave  bus
);

  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] rdata;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [DATA_W-1:0] c_q;
  logic [DATA_W-1:0] ain;
  logic [DATA_W-1:0] bin;
  alu_out_t          alu;
  logic              z_q;
  logic              n_q;
  logic              v_q;

  always_comb begin
    idx = bus.rn;
    case (bus.reg_sel)
      SEL_RM:  idx = bus.rm;
      SEL_RD:  idx = bus.rd;
      default: idx = bus.rn;
    endcase
  end

  always_comb begin
    wdata = c_q;
    case (bus.wb_sel)
      WB_PC:    wdata = {8'b0, bus.pc};
      WB_IMM8:  wdata = bus.sximm8;
      WB_MDATA: wdata = bus.mdata;
      default:  wdata = c_q;
    endcase
  end

  regfile u_regfile (
    .clk   (clk),
    .rst_n (rst_n),
    .idx   (idx),
    .w_en  (bus.w_en),
    .wdata (wdata),
    .rdata (rdata)
  );

  assign ain = bus.sel_A ? '0 : a_q;
  assign bin = bus.sel_B ? bus.sximm5 : shift16(bus.shift_op, b_q);
  assign alu = alu16(bus.ALU_op, ain, bin);

  // A/B sample the pre-write read value, so a same-edge write is seen only next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
      c_q <= '0;
      z_q <= 1'b0;
      n_q <= 1'b0;
      v_q <= 1'b0;
    end else begin
      if (bus.en_A) a_q <= rdata;
      if (bus.en_B) b_q <= rdata;
      if (bus.en_C) c_q <= alu.result;
      if (bus.en_status) begin
        z_q <= (alu.result == '0);
        n_q <= alu.result[DATA_W-1];
        v_q <= alu.v;
      end
    end
  end

  assign bus.datapath_out = c_q;
  assign bus.Z            = z_q;
  assign bus.N            = n_q;
  assign bus.V            = v_q;

endmodule
